song_sequencer: RTL and testbench
=================================

# song_sequencer

Plays one of four built-in songs as a stream of note codes, under the control of the `pause` and `song_num` signals produced by the button controller. Sits between the button controller and the tone/PWM generator, and is active only in autoplay mode (`mode == 3'b011`). Steps a per-song note index once per beat. Emits a registered note code, status flags and a one-cycle end-of-song pulse.

## Interface
Parameters:
- `BEAT_CYCLES`, default 12_500_000: clock cycles per note (beat); legal range 2..2^25-1.
- `SONG_LEN`, fixed at 16: notes per song.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mode`  in  3  operating mode; the block is active only when the value is 3'b011.
- `pause`  in  1  level; 1 freezes playback.
- `song_num`  in  2  selected song, 0..3.
- `note`  out  4  current note code: 0 = rest, 1..7 = do..ti; registered.
- `note_idx`  out  4  index of the current note, 0..15.
- `playing`  out  1  1 while in PLAY.
- `song_done`  out  1  one-cycle pulse when the last note's beat expires.

## Operation
- ROM, indexed [song][idx]:
  - Song 0: 1,1,5,5,6,6,5,0,4,4,3,3,2,2,1,0.
  - Song 1: 1,2,3,4,5,6,7,0, then repeated.
  - Song 2: 7,6,5,4,3,2,1,0, then repeated.
  - Song 3: 1,0,1,0,… alternating.
- Internal registers:
  - `cur_song[1:0]`: song currently being played.
  - `beat_cnt[24:0]`: cycles elapsed in the current beat.
  - `idx[3:0]`: current note index.
  - State: IDLE, PLAY, PAUSED, DONE.
- Reset (async, `rst_n = 0`):
  - State goes to IDLE.
  - `note`, `note_idx`, `playing`, `song_done`, `beat_cnt`, `cur_song` all go to 0.
  - Takes effect immediately, including mid-song.
- Event priority each cycle, highest first: mode exit, song change, pause, beat tick.
  - Mode exit (`mode != 3'b011`): from any state, go to IDLE and clear all counters and outputs.
  - IDLE with mode = 3'b011: load `cur_song <= song_num`, `idx <= 0`, `beat_cnt <= 0`, `note <= ROM[song_num][0]`. Go to PLAY, or to PAUSED with `note <= 0` if `pause = 1`.
  - Song change (`song_num != cur_song`, mode active, any non-IDLE state): same load as above with the new song; the song restarts from index 0.
  - PLAY with `pause = 1`: go to PAUSED, `note <= 0`; `idx` and `beat_cnt` hold.
  - PAUSED with `pause = 0`: go to PLAY, `note <= ROM[cur_song][idx]`; `beat_cnt` resumes from its held value.
  - Beat tick in PLAY when `beat_cnt == BEAT_CYCLES-1`: `beat_cnt <= 0`.
    - If `idx < 15`: `idx <= idx+1`, `note <= ROM[cur_song][idx+1]`.
    - If `idx == 15`: go to DONE, `note <= 0`, `song_done <= 1` for one cycle; `idx` stays at 15.
  - DONE: hold silent. `pause` is ignored. Exit only via a song change (restarts) or mode exit.
- `playing` = (state == PLAY), registered. `note_idx` mirrors `idx`.

## Timing
- All outputs are registered and change only on the rising edge of `clk`, except during async reset.
- Mode becomes active at edge N: at edge N+1, `playing = 1` and `note = ROM[s][0]`.
- Beat length is exactly `BEAT_CYCLES` cycles of PLAY. Paused cycles do not count toward the beat.
- A song change takes effect one edge after `song_num` changes; the new song's note 0 is visible at that edge.
- `song_done` is high for exactly one cycle, coincident with the transition to DONE.
- Pause and beat tick in the same cycle: pause wins, so the tick is deferred. `beat_cnt` holds at BEAT_CYCLES-1, and the tick fires on the first PLAY cycle after resume.
- Song change and pause in the same cycle: restart into PAUSED.

## Test plan
All scenarios use `BEAT_CYCLES = 4`.
- Reset then `mode = 3'b011`, `song_num = 0`, `pause = 0`:
  - Note sequence is 1,1,5,5,6,6,5,0,4,4,3,3,2,2,1,0, each held 4 cycles.
  - `song_done` pulses once, 64 cycles after PLAY entry.
  - Afterwards `note = 0`, `playing = 0`.
- Song 1 playing, `pause = 1` at `idx = 2`, `beat_cnt = 1`, held 10 cycles:
  - `note = 0` and `idx = 2` throughout the pause.
  - On release, `note = 3` for 3 more cycles, then 4.
- Switch `song_num` 0→2 at `idx = 5`: next edge gives `idx = 0`, `note = 7`, `playing = 1`.
- In DONE, toggle `pause`: no change. Then set `song_num = 3`: restarts, `note = 1`.
- Drive `mode = 3'b001` mid-song, then back to 3'b011: outputs clear; the song restarts at `idx = 0`.
- Assert `rst_n = 0` asynchronously mid-beat: all outputs are 0 before the next clock edge. After release, the block re-enters PLAY at `idx = 0`.

Source files
------------

// File: rtl/song_sequencer.sv
// Autoplay song sequencer: steps through one of four 16-note songs once per beat,
// with pause, restart-on-song-change and a one-cycle end-of-song pulse.
module song_sequencer #(
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned SONG_LEN    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] mode,
    input  logic       pause,
    input  logic [1:0] song_num,
    output logic [3:0] note,
    output logic [3:0] note_idx,
    output logic       playing,
    output logic       song_done
);

    localparam logic [2:0]  MODE_AUTO = 3'b011;
    localparam logic [24:0] BEAT_LAST = 25'(BEAT_CYCLES - 1);
    localparam logic [3:0]  IDX_LAST  = 4'(SONG_LEN - 1);
    // Song 0 packed with index 15 in the top nibble.
    localparam logic [63:0] SONG0 = {4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4,
                                     4'd0, 4'd5, 4'd6, 4'd6, 4'd5, 4'd5, 4'd1, 4'd1};

    typedef enum logic [1:0] {IDLE, PLAY, PAUSED, DONE} state_t;

    state_t      state;
    logic [1:0]  cur_song;
    logic [24:0] beat_cnt;
    logic [3:0]  idx;

    function automatic logic [3:0] rom(input logic [1:0] s, input logic [3:0] i);
        logic [3:0] n;
        case (s)
            2'd0:    n = SONG0[{i, 2'b00} +: 4];
            2'd1:    n = (i[2:0] == 3'd7) ? 4'd0 : {1'b0, i[2:0]} + 4'd1;
            2'd2:    n = (i[2:0] == 3'd7) ? 4'd0 : 4'd7 - {1'b0, i[2:0]};
            default: n = i[0] ? 4'd0 : 4'd1;
        endcase
        return n;
    endfunction

    assign note_idx = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_song  <= 2'd0;
            beat_cnt  <= '0;
            idx       <= '0;
            note      <= '0;
            playing   <= 1'b0;
            song_done <= 1'b0;
        end else begin
            song_done <= 1'b0;
            if (mode != MODE_AUTO) begin
                state    <= IDLE;
                cur_song <= 2'd0;
                beat_cnt <= '0;
                idx      <= '0;
                note     <= '0;
                playing  <= 1'b0;
            end else if (state == IDLE || song_num != cur_song) begin
                // (Re)start the selected song; a simultaneous pause lands in PAUSED.
                cur_song <= song_num;
                idx      <= '0;
                beat_cnt <= '0;
                state    <= pause ? PAUSED : PLAY;
                note     <= pause ? 4'd0 : rom(song_num, 4'd0);
                playing  <= !pause;
            end else begin
                case (state)
                    PLAY: begin
                        if (pause) begin
                            state   <= PAUSED;
                            note    <= '0;
                            playing <= 1'b0;
                        end else if (beat_cnt == BEAT_LAST) begin
                            beat_cnt <= '0;
                            if (idx != IDX_LAST) begin
                                idx  <= idx + 4'd1;
                                note <= rom(cur_song, idx + 4'd1);
                            end else begin
                                state     <= DONE;
                                note      <= '0;
                                playing   <= 1'b0;
                                song_done <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 25'd1;
                        end
                    end
                    PAUSED: begin
                        // beat_cnt is untouched, so a deferred tick fires right after resume.
                        if (!pause) begin
                            state   <= PLAY;
                            note    <= rom(cur_song, idx);
                            playing <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with BEAT_CYCLES = 4; expected outputs go
// through a scoreboard queue and are popped at each sample point.
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       pause = 1'b0;
    logic [1:0] song_num = 2'd0;
    logic [3:0] note, note_idx;
    logic       playing, song_done;

    int checks = 0;
    int errors = 0;

    song_sequencer #(.BEAT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .pause(pause), .song_num(song_num),
        .note(note), .note_idx(note_idx), .playing(playing), .song_done(song_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] note;
        logic [3:0] idx;
        logic       playing;
        logic       done;
    } exp_t;

    exp_t q[$];

    logic [3:0] s0 [16] = '{4'd1, 4'd1, 4'd5, 4'd5, 4'd6, 4'd6, 4'd5, 4'd0,
                            4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0};
    logic [3:0] s1 [8]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};
    logic [3:0] s2 [8]  = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

    task automatic push(input string tag, input logic [3:0] n, input logic [3:0] i,
                        input logic p, input logic d);
        exp_t e;
        e.tag = tag; e.note = n; e.idx = i; e.playing = p; e.done = d;
        q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [9:0] got, want;
        e = q.pop_front();
        got  = {note, note_idx, playing, song_done};
        want = {e.note, e.idx, e.playing, e.done};
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got note=%0d idx=%0d playing=%0b done=%0b, expected note=%0d idx=%0d playing=%0b done=%0b",
                   e.tag, note, note_idx, playing, song_done, e.note, e.idx, e.playing, e.done);
        end
    endtask

    // Push the expectation for the next edge, advance one clock, then compare.
    task automatic step(input string tag, input logic [3:0] n, input logic [3:0] i,
                        input logic p, input logic d);
        push(tag, n, i, p, d);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        // Reset state
        #12;
        push("reset", 4'd0, 4'd0, 1'b0, 1'b0);
        check();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push("idle", 4'd0, 4'd0, 1'b0, 1'b0);
        check();

        // Full song 0: each note held 4 cycles, song_done 64 cycles after entry
        mode = 3'b011;
        step("s0_entry", s0[0], 4'd0, 1'b1, 1'b0);
        for (int j = 1; j < 64; j++)
            step("s0_seq", s0[j/4], 4'(j/4), 1'b1, 1'b0);
        step("s0_done_pulse", 4'd0, 4'd15, 1'b0, 1'b1);
        step("s0_done_hold", 4'd0, 4'd15, 1'b0, 1'b0);

        // DONE ignores pause; a song change restarts
        pause = 1'b1;
        step("done_pause_on", 4'd0, 4'd15, 1'b0, 1'b0);
        pause = 1'b0;
        step("done_pause_off", 4'd0, 4'd15, 1'b0, 1'b0);
        song_num = 2'd3;
        step("done_restart_s3", 4'd1, 4'd0, 1'b1, 1'b0);

        // Mode exit clears, re-entry starts song 0 at idx 0
        mode = 3'b001;
        step("mode_exit", 4'd0, 4'd0, 1'b0, 1'b0);
        song_num = 2'd0;
        mode = 3'b011;
        step("mode_reenter", s0[0], 4'd0, 1'b1, 1'b0);
        for (int j = 1; j <= 20; j++)
            step("s0_to_idx5", s0[j/4], 4'(j/4), 1'b1, 1'b0);

        // Song change 0 -> 2 at idx 5
        song_num = 2'd2;
        step("switch_s2", 4'd7, 4'd0, 1'b1, 1'b0);
        for (int j = 1; j <= 6; j++)
            step("s2_seq", s2[j/4], 4'(j/4), 1'b1, 1'b0);
        mode = 3'b001;
        step("mode_exit_mid", 4'd0, 4'd0, 1'b0, 1'b0);
        mode = 3'b011;
        step("mode_restart_s2", 4'd7, 4'd0, 1'b1, 1'b0);

        // Song 1, pause at idx 2 / beat_cnt 1 for 10 cycles
        song_num = 2'd1;
        step("switch_s1", s1[0], 4'd0, 1'b1, 1'b0);
        for (int j = 1; j <= 9; j++)
            step("s1_seq", s1[j/4], 4'(j/4), 1'b1, 1'b0);
        pause = 1'b1;
        for (int j = 0; j < 10; j++)
            step("s1_paused", 4'd0, 4'd2, 1'b0, 1'b0);
        pause = 1'b0;
        for (int j = 0; j < 3; j++)
            step("s1_resume", 4'd3, 4'd2, 1'b1, 1'b0);
        step("s1_next", 4'd4, 4'd3, 1'b1, 1'b0);

        // Pause coinciding with the tick defers it to the first PLAY cycle after resume
        for (int j = 0; j < 3; j++)
            step("s1_to_last", 4'd4, 4'd3, 1'b1, 1'b0);
        pause = 1'b1;
        step("tick_pause", 4'd0, 4'd3, 1'b0, 1'b0);
        pause = 1'b0;
        step("tick_resume", 4'd4, 4'd3, 1'b1, 1'b0);
        step("tick_deferred", 4'd5, 4'd4, 1'b1, 1'b0);

        // Song change together with pause restarts into PAUSED
        pause = 1'b1;
        song_num = 2'd3;
        step("change_pause", 4'd0, 4'd0, 1'b0, 1'b0);
        pause = 1'b0;
        step("change_resume", 4'd1, 4'd0, 1'b1, 1'b0);

        // Async reset mid-beat clears before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        push("async_reset", 4'd0, 4'd0, 1'b0, 1'b0);
        check();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_play", 4'd1, 4'd0, 1'b1, 1'b0);
        step("post_reset_s3", 4'd1, 4'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
